data_mem_responder: RTL and testbench

- Responder (memory side) of the data-memory request interface driven by the pipeline's load/store unit.
- Accepts one read or write request at a time and returns a single-cycle `valid` pulse after a programmable wait-state latency; read data is returned on `rdata`.
- Backs a word-addressed synchronous array. A preload port lets the benches and the boot flow initialise contents.
- Sits between the MEM-stage load/store unit and the data store. It also serves as the synthesizable data-memory model in system simulation.

---
 rtl/data_mem_pkg.sv | 13 +
 rtl/sram_sp.sv | 26 ++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_OFFSET_W = 2;

endpackage

// File: rtl/sram_sp.sv
// Single-port word array: synchronous write, asynchronous read so the owner
// decides exactly which edge captures read data.
module sram_sp #(
    parameter int N     = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [N-1:0]             din,
    output logic [N-1:0]             dout
);

    logic [N-1:0] mem_r [DEPTH];

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[idx] <= din;
        end
    end

    assign dout = mem_r[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store unit: one request at a time,
// fixed wait-state latency, single-cycle completion pulse, backdoor preload.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int N       = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     proc_req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [N-1:0]             wdata,
    output logic                     mem_ready,
    output logic                     valid,
    output logic [N-1:0]             rdata,
    input  logic                     init_en,
    input  logic [$clog2(DEPTH)-1:0] init_addr,
    input  logic [N-1:0]             init_data
);

    localparam int   IDX_W    = $clog2(DEPTH);
    localparam int   CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int   CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;
    localparam logic LAT_ONE  = (LATENCY == 1);

    dmem_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             we_r;
    logic [IDX_W-1:0] idx_r;
    logic [N-1:0]     wdata_r;
    logic             valid_r;
    logic [N-1:0]     rdata_r;

    logic             accept_s;
    logic [IDX_W-1:0] req_idx_s;
    logic             sram_en_s;
    logic             sram_we_s;
    logic [IDX_W-1:0] sram_idx_s;
    logic [N-1:0]     sram_din_s;
    logic [N-1:0]     sram_dout_s;
    logic             unused_addr_s;

    // Byte offset and bits above the array size are dropped: aligned access, modulo wrap.
    assign req_idx_s     = addr[IDX_W+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
    assign unused_addr_s = ^{addr[ADDR_W-1:IDX_W+BYTE_OFFSET_W], addr[BYTE_OFFSET_W-1:0]};

    assign mem_ready = rst && (state_r == IDLE) && !init_en;
    assign accept_s  = proc_req && mem_ready;
    assign valid     = valid_r;
    assign rdata     = rdata_r;

    // Array port mux: preload only in IDLE, request write only while leaving RESP.
    always_comb begin
        sram_en_s  = 1'b0;
        sram_we_s  = 1'b0;
        sram_idx_s = idx_r;
        sram_din_s = wdata_r;
        case (state_r)
            IDLE: begin
                if (init_en) begin
                    sram_en_s  = 1'b1;
                    sram_we_s  = 1'b1;
                    sram_idx_s = init_addr;
                    sram_din_s = init_data;
                end else begin
                    sram_idx_s = req_idx_s;
                end
            end
            WAIT: begin
                sram_idx_s = idx_r;
            end
            RESP: begin
                if (we_r) begin
                    sram_en_s = 1'b1;
                    sram_we_s = 1'b1;
                end else begin
                    sram_en_s = 1'b0;
                end
            end
            default: begin
                sram_en_s = 1'b0;
            end
        endcase
    end

    sram_sp #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk  (clk),
        .en   (sram_en_s),
        .we   (sram_we_s),
        .idx  (sram_idx_s),
        .din  (sram_din_s),
        .dout (sram_dout_s)
    );

    // Request FSM with capture registers; read data is latched on entry to RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            we_r    <= 1'b0;
            idx_r   <= '0;
            wdata_r <= '0;
            valid_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (accept_s) begin
                        we_r    <= we;
                        idx_r   <= req_idx_s;
                        wdata_r <= wdata;
                        if (LAT_ONE) begin
                            state_r <= RESP;
                            valid_r <= 1'b1;
                            if (!we) begin
                                rdata_r <= sram_dout_s;
                            end
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_W'(CNT_INIT);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == '0) begin
                        state_r <= RESP;
                        valid_r <= 1'b1;
                        if (!we_r) begin
                            rdata_r <= sram_dout_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESP: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for the main table and corner sequences,
// LATENCY=1 instance for the single-cycle and preload-collision cases.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        proc_req2 = 1'b0, we2 = 1'b0, init_en2 = 1'b0;
    logic [31:0] addr2 = 32'h0, wdata2 = 32'h0, init_data2 = 32'h0;
    logic [9:0]  init_addr2 = 10'd0;
    logic        mem_ready2, valid2;
    logic [31:0] rdata2;

    logic        proc_req1 = 1'b0, we1 = 1'b0, init_en1 = 1'b0;
    logic [31:0] addr1 = 32'h0, wdata1 = 32'h0, init_data1 = 32'h0;
    logic [9:0]  init_addr1 = 10'd0;
    logic        mem_ready1, valid1;
    logic [31:0] rdata1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.N(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .proc_req(proc_req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .mem_ready(mem_ready2), .valid(valid2), .rdata(rdata2),
        .init_en(init_en2), .init_addr(init_addr2), .init_data(init_data2)
    );

    data_mem_responder #(.N(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .proc_req(proc_req1), .we(we1), .addr(addr1),
        .wdata(wdata1), .mem_ready(mem_ready1), .valid(valid1), .rdata(rdata1),
        .init_en(init_en1), .init_addr(init_addr1), .init_data(init_data1)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic pre2(input logic [9:0] i, input logic [31:0] d);
        @(negedge clk);
        init_en2 = 1'b1; init_addr2 = i; init_data2 = d;
        #1 chk("pre_ready_low", {31'd0, mem_ready2}, 32'd0);
        @(negedge clk);
        init_en2 = 1'b0;
    endtask

    task automatic req2(input string nm, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        proc_req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
        #1 chk({nm, "_ready"}, {31'd0, mem_ready2}, 32'd1);
        @(negedge clk);
        proc_req2 = 1'b0; we2 = 1'b1; addr2 = 32'hFFFF_FFFC; wdata2 = 32'hFFFF_FFFF;
        #1 chk({nm, "_busy"}, {31'd0, mem_ready2}, 32'd0);
        lat = 1;
        while (valid2 !== 1'b1 && lat < 8) begin
            @(negedge clk);
            #1 lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'd2);
        chk({nm, "_rdata"}, rdata2, exp);
        we2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_v;

        vecs[0] = '{"rd_w5",      1'b0, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{"wr_0x20",    1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[2] = '{"rd_0x20",    1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678};
        vecs[3] = '{"rd_wrap0",   1'b0, 32'h0000_1003, 32'h0,         32'hA5A5_0000};
        vecs[4] = '{"wr_wrap9",   1'b1, 32'h0000_1024, 32'hCAFE_F00D, 32'hA5A5_0000};
        vecs[5] = '{"rd_w9",      1'b0, 32'h0000_0024, 32'h0,         32'hCAFE_F00D};
        vecs[6] = '{"rd_w5_off3", 1'b0, 32'h0000_0017, 32'h0,         32'hDEAD_BEEF};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid2", {31'd0, valid2}, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_ready2", {31'd0, mem_ready2}, 32'd0);
        chk("rst_valid1", {31'd0, valid1}, 32'd0);
        chk("rst_ready1", {31'd0, mem_ready1}, 32'd0);
        rst = 1'b1;
        #1 chk("rel_ready2", {31'd0, mem_ready2}, 32'd1);

        pre2(10'd5, 32'hDEAD_BEEF);
        pre2(10'd0, 32'hA5A5_0000);
        pre2(10'd7, 32'h7777_7777);

        for (int v = 0; v < 7; v++) begin
            req2(vecs[v].name, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
        end

        // Request held continuously; WAIT/RESP inputs and preloads must be ignored.
        prev_v = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                proc_req2 = 1'b1; we2 = 1'b0; init_en2 = 1'b0;
                addr2 = ((k / 3) % 2 == 0) ? 32'h14 : 32'h24;
            end else begin
                proc_req2 = (k != 11); we2 = 1'b1; addr2 = 32'h1C; wdata2 = 32'hBAD0_BAD0;
                init_en2 = 1'b1; init_addr2 = 10'd5; init_data2 = 32'h0;
            end
            #1;
            chk("hold_ready", {31'd0, mem_ready2}, {31'd0, (k % 3 == 0)});
            chk("hold_valid", {31'd0, valid2}, {31'd0, (k % 3 == 2)});
            chk("hold_noconsec", {31'd0, prev_v & valid2}, 32'd0);
            prev_v = valid2;
            if (k % 3 == 2) begin
                chk("hold_rdata", rdata2, ((k / 3) % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
            end
        end
        @(negedge clk);
        init_en2 = 1'b0; proc_req2 = 1'b0; we2 = 1'b0;
        req2("rd_w7_intact", 1'b0, 32'h1C, 32'h0, 32'h7777_7777);

        // Reset in WAIT of a write to word 7.
        @(negedge clk);
        proc_req2 = 1'b1; we2 = 1'b1; addr2 = 32'h1C; wdata2 = 32'hFFFF_0000;
        @(negedge clk);
        proc_req2 = 1'b0; we2 = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid2}, 32'd0);
        chk("midrst_rdata", rdata2, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("postrst_ready", {31'd0, mem_ready2}, 32'd1);
        chk("postrst_rdata", rdata2, 32'd0);
        @(negedge clk);
        #1 chk("postrst_novalid", {31'd0, valid2}, 32'd0);
        req2("rd_w7_after_rst", 1'b0, 32'h1C, 32'h0, 32'h7777_7777);

        // LATENCY=1: preload collides with a request, then the request completes next cycle.
        @(negedge clk);
        proc_req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0C;
        init_en1 = 1'b1; init_addr1 = 10'd3; init_data1 = 32'h3333_0003;
        #1 chk("l1_ready_init", {31'd0, mem_ready1}, 32'd0);
        @(negedge clk);
        chk("l1_no_accept", {31'd0, valid1}, 32'd0);
        init_en1 = 1'b0;
        #1 chk("l1_ready", {31'd0, mem_ready1}, 32'd1);
        @(negedge clk);
        proc_req1 = 1'b0;
        #1;
        chk("l1_valid", {31'd0, valid1}, 32'd1);
        chk("l1_rdata", rdata1, 32'h3333_0003);
        chk("l1_busy", {31'd0, mem_ready1}, 32'd0);
        @(negedge clk);
        #1;
        chk("l1_valid_drop", {31'd0, valid1}, 32'd0);
        chk("l1_ready_again", {31'd0, mem_ready1}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
